switch_input_capture: RTL
=========================

SWITCH_INPUT_CAPTURE -- requirements
Module: switch_input_capture

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4: number of consecutive equal synchronized samples needed to accept a new switch value (legal 2..255).
REQ-002 SHALL have parameter DATA_W, default 8: width of the captured data word.
REQ-003 SHALL have port SEGclk, input, 1: sampling clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: reset, synchronous, active-high, sampled on SEGclk.
REQ-005 SHALL have port sw_data_raw, input, DATA_W: asynchronous data switches.
REQ-006 SHALL have port sw_enter_raw, input, 1: asynchronous commit switch/button.
REQ-007 SHALL have port ovr_clear, input, 1: synchronous clear of the overrun flag.
REQ-008 SHALL have port in_ready, input, 1: CPU accepts the presented word this cycle.
REQ-009 SHALL have port in_valid, output, 1: a captured word is presented.
REQ-010 SHALL have port in_data, output, DATA_W: captured word, valid while in_valid=1.
REQ-011 SHALL have port sw_stable, output, DATA_W: current debounced data switches, for LED echo.
REQ-012 SHALL have port overrun, output, 1: sticky flag, commit lost while a word was pending.

Function
REQ-013 SHALL pass {sw_enter_raw, sw_data_raw} through a two-flop synchronizer (sync1, sync2).
REQ-014 Debouncer SHALL hold cand and cnt: if sync2!=cand then cand<=sync2, cnt<=0; else if cnt<DEBOUNCE_CYCLES-1 then cnt++; else deb<=cand.
REQ-015 Latency: a raw change stable from sampling edge 1 SHALL appear in deb after edge DEBOUNCE_CYCLES+3; a raw pulse shorter than DEBOUNCE_CYCLES+1 edges SHALL never change deb.
REQ-016 sw_stable SHALL equal the data field of deb.
REQ-017 commit SHALL be the combinational term deb_enter & ~deb_enter_prev, where deb_enter_prev is deb_enter registered once.
REQ-018 FSM states SHALL be IDLE (in_valid=0) and PRESENT (in_valid=1).
REQ-019 IDLE: on commit, load in_data<=sw_stable and go to PRESENT (in_valid rises the edge after deb_enter rises).
REQ-020 PRESENT: in_data and in_valid SHALL remain stable until in_ready=1 is sampled.
REQ-021 PRESENT, in_ready=1, no commit: go to IDLE.
REQ-022 PRESENT, in_ready=1 and commit in the same cycle: old word is accepted, in_data<=sw_stable, stay in PRESENT; overrun unchanged.
REQ-023 PRESENT, in_ready=0 and commit: keep the old word and set overrun<=1.
REQ-024 ovr_clear=1 SHALL clear overrun; if a set condition occurs in the same cycle, set wins.
REQ-025 in_ready while IDLE SHALL be ignored.
REQ-026 Releasing the enter switch SHALL generate no commit; each press yields at most one word.

Reset
REQ-027 On reset: sync1, sync2, cand, deb, deb_enter_prev<=0; cnt<=0; state<=IDLE; in_valid=0; in_data=0; overrun=0; sw_stable=0.
REQ-028 Reset asserted in PRESENT SHALL drop the pending word without a handshake; an enter switch held through reset deassertion SHALL commit once after debounce, because deb_enter_prev resets to 0.

Structure
REQ-029 The shared package SHALL hold the FSM state encoding (IDLE=0, PRESENT=1) and the default DEBOUNCE_CYCLES constant.
REQ-030 The synchronizer and debouncer SHALL be one sub-module, input_debounce, parameterized by width and DEBOUNCE_CYCLES; the FSM SHALL stay in the top module.

Verification (DEBOUNCE_CYCLES=4, DATA_W=8)
REQ-031 Set data=0xA5 and hold it, then raise enter at edge 1 and hold it -> in_valid=1 and in_data=0xA5 after edge 8; hold in_ready=0 for 5 cycles -> values unchanged; pulse in_ready once -> in_valid=0 next edge.
REQ-032 Glitch data from 0x00 to 0xFF for 3 edges -> sw_stable stays 0x00 and no in_valid.
REQ-033 With 0x11 pending and in_ready=0, release enter, set 0x22, press enter -> overrun=1 and in_data remains 0x11; ovr_clear -> overrun=0.
REQ-034 Assert in_ready in the same cycle as a commit of 0x33 while 0x11 is pending -> 0x11 is accepted, in_data=0x33, in_valid stays 1, overrun=0.
REQ-035 Assert reset while in PRESENT -> next edge in_valid=0, in_data=0x00, overrun=0; with enter held, one new word appears after debounce.

Source files
------------

// File: rtl/switch_input_capture_pkg.sv
// switch_input_capture_pkg
//   Shared definitions for the switch input capture block: the handshake
//   FSM state encoding and the default debounce length.
package switch_input_capture_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 4;

endpackage

// File: rtl/switch_input_capture_input_debounce.sv
// input_debounce
//   Two-flop synchronizer followed by a whole-vector debouncer. A new value
//   is accepted only after DEBOUNCE_CYCLES consecutive equal synchronized
//   samples; any bit change restarts the count.
// Ports:
//   clk   - sampling clock
//   reset - synchronous, active-high
//   raw   - asynchronous switch inputs
//   deb   - debounced value
module input_debounce
    import switch_input_capture_pkg::*;
#(
    parameter int unsigned WIDTH           = 9,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] deb
);

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] cand;
    logic [7:0]       cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            cand  <= '0;
            cnt   <= '0;
            deb   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 != cand) begin
                cand <= sync2;
                cnt  <= '0;
            end else if (cnt < CNT_LAST) begin
                cnt <= cnt + 8'd1;
            end else begin
                deb <= cand;
            end
        end
    end

endmodule

// File: rtl/switch_input_capture.sv
// switch_input_capture
//   Captures a data word from debounced switches when the enter switch is
//   pressed and presents it to the CPU with a valid/ready handshake.
// Ports:
//   SEGclk       - sampling clock
//   reset        - synchronous, active-high
//   sw_data_raw  - asynchronous data switches
//   sw_enter_raw - asynchronous commit switch
//   ovr_clear    - clears the overrun flag (a simultaneous set wins)
//   in_ready     - CPU accepts the presented word
//   in_valid     - a captured word is presented
//   in_data      - captured word
//   sw_stable    - debounced data switches (LED echo)
//   overrun      - sticky: a commit was lost while a word was pending
module switch_input_capture
    import switch_input_capture_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned DATA_W          = 8
) (
    input  logic              SEGclk,
    input  logic              reset,
    input  logic [DATA_W-1:0] sw_data_raw,
    input  logic              sw_enter_raw,
    input  logic              ovr_clear,
    input  logic              in_ready,
    output logic              in_valid,
    output logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] sw_stable,
    output logic              overrun
);

    logic [DATA_W:0]   deb;
    logic              deb_enter;
    logic              deb_enter_prev;
    logic              commit;

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] data_next;
    logic              overrun_next;

    // Enter and data are debounced as one vector so the captured word is
    // always the one that was stable alongside the enter press.
    input_debounce #(
        .WIDTH           (DATA_W + 1),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_input_debounce (
        .clk   (SEGclk),
        .reset (reset),
        .raw   ({sw_enter_raw, sw_data_raw}),
        .deb   (deb)
    );

    assign sw_stable = deb[DATA_W-1:0];
    assign deb_enter = deb[DATA_W];

    always_ff @(posedge SEGclk) begin
        if (reset) begin
            deb_enter_prev <= 1'b0;
        end else begin
            deb_enter_prev <= deb_enter;
        end
    end

    // Rising edge only: releasing the switch never commits.
    assign commit = deb_enter & ~deb_enter_prev;

    always_ff @(posedge SEGclk) begin
        if (reset) begin
            state   <= IDLE;
            in_data <= '0;
            overrun <= 1'b0;
        end else begin
            state   <= state_next;
            in_data <= data_next;
            overrun <= overrun_next;
        end
    end

    always_comb begin
        state_next   = state;
        data_next    = in_data;
        overrun_next = ovr_clear ? 1'b0 : overrun;
        case (state)
            IDLE: begin
                if (commit) begin
                    data_next  = sw_stable;
                    state_next = PRESENT;
                end
            end
            PRESENT: begin
                if (in_ready) begin
                    if (commit) begin
                        data_next = sw_stable;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (commit) begin
                    overrun_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign in_valid = (state == PRESENT);

endmodule
